ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
Parametrised EX->MEM pipeline stage register with a valid/ready handshake, flush and backpressure. It carries the writeback fields (rd_we, rd_addr, rd_data) plus the memory-request fields from EX to MEM. Every accepted beat is captured, including beats with rd_we=0, such as stores. An optional 2-entry skid buffer breaks the combinational ready path. A saturating stall counter is provided for performance debug.

Parameters:
REG_W, 32, register/data/address width
REG_ADDR_W, 5, register index width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush_i  input  1  drop all held beats (branch/exception kill)
in_valid_i  input  1  EX beat valid
in_ready_o  output  1  stage can accept a beat
rd_we_i  input  1  writeback enable
rd_addr_i  input  REG_ADDR_W  writeback index
rd_data_i  input  REG_W  ALU result
mem_re_i  input  1  load request
mem_we_i  input  1  store request
mem_size_i  input  2  0=byte, 1=half, 2=word, 3=reserved
mem_wdata_i  input  REG_W  store data
out_valid_o  output  1  MEM beat valid
out_ready_i  input  1  MEM accepts beat
rd_we_o  output  1  registered rd_we
rd_addr_o  output  REG_ADDR_W  registered rd_addr
rd_data_o  output  REG_W  registered rd_data (also memory address when mem_re/mem_we)
mem_re_o  output  1  registered mem_re
mem_we_o  output  1  registered mem_we
mem_size_o  output  2  registered mem_size
mem_wdata_o  output  REG_W  registered mem_wdata
stall_cnt_o  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Clocking and reset: single clock `clk`; synchronous active-low reset `rst_n`, sampled only on the rising edge.
- Reset values:
  - All payload outputs 0.
  - out_valid_o=0, stall_cnt_o=0.
  - in_ready_o=1 in the first cycle after reset is released.
- Handshakes:
  - Input handshake: in_valid_i & in_ready_o.
  - Output handshake: out_valid_o & out_ready_i.
  - Payload fields are a single packed word; all fields move together.
- Latency: 1 cycle from an accepted input beat to out_valid_o=1 when the stage is empty.
- Ordering: beats leave strictly in acceptance order. No beat is lost or duplicated under any in/out handshake combination.
- Output stability: while out_valid_o=1 and out_ready_i=0, every output is held stable.
- Bubbles: when out_valid_o=0, payload outputs hold their last value. Consumers must qualify with out_valid_o.
- Flush:
  - flush_i=1 clears all valid bits at the next edge.
  - Payload registers are not cleared.
  - An input beat offered in the same cycle as flush is discarded.
  - Flush has priority over all handshakes; reset has priority over flush.
  - stall_cnt_o is not affected by flush.
- Stall counter:
  - Increments by 1 each cycle with out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- mem_size_i=3: passed through unmodified; MEM decides how to handle it.
- Concurrent mem_re_i=1 and mem_we_i=1: passed through unmodified; illegal upstream.

Optional Feature:
Macro EX_MEM_SKID_BUF_EN.
- Defined: 2-entry design (main + skid register). States and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> TWO (the new beat goes to skid); drain & !accept -> EMPTY; accept & drain -> ONE with main replaced.
  - TWO: drain -> ONE with skid moved to main.
  - in_ready_o is a pure register output: 1 in EMPTY/ONE, 0 in TWO. No combinational path from out_ready_i.
  - Flush returns the block to EMPTY.
- Undefined: single register.
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - Full throughput with one entry; no skid register is instantiated.

Test Plan:
- Reset pass-through:
  - Stimulus: hold rst_n=0 for 3 cycles, then release. Send rd_we=1, rd_addr=5, rd_data=0x1234, out_ready_i=1.
  - Required: after reset all outputs 0; out_valid_o=1 with rd_addr_o=5, rd_data_o=0x1234 one cycle later.
- Store beat with rd_we=0:
  - Stimulus: mem_we=1, mem_size=2, rd_data=0x8000_0010, mem_wdata=0xDEAD_BEEF.
  - Required: beat appears at the outputs unchanged.
- Backpressure burst:
  - Stimulus: 8 beats rd_data=1..8 back-to-back; out_ready_i toggles 1,0,0,1,... pseudo-randomly.
  - Required: outputs 1..8 in order, each held stable while stalled; stall_cnt_o equals the number of stalled cycles.
- Flush:
  - Stimulus: 2 beats held (skid enabled) or 1 beat held (disabled), with out_ready_i=0, then flush_i=1 together with in_valid_i=1.
  - Required: out_valid_o=0 next cycle; the flushed input beat never appears; in_ready_o=1.
- Counter saturation:
  - Stimulus: CNT_W=4, out_valid_o=1, out_ready_i=0 for 20 cycles.
  - Required: stall_cnt_o stops at 15.
- Mid-operation reset:
  - Stimulus: rst_n=0 while holding a stalled beat.
  - Required: next edge gives out_valid_o=0, stall_cnt_o=0, all payload outputs 0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage register with a valid/ready handshake,
// flush and backpressure. Every accepted beat is captured, including beats
// with rd_we=0 such as stores, and leaves in acceptance order.
//
// Build option: define EX_MEM_SKID_BUF_EN to get the 2-entry skid version.
// In that version in_ready_o is a pure register output. Without it, the
// stage is a single register with a combinational ready path.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   flush_i             drop all held beats; an input beat in the same cycle is dropped
//   in_valid_i/o_ready  EX side handshake (in_ready_o)
//   rd_*_i, mem_*_i     incoming writeback and memory-request payload
//   out_valid_o/i_ready MEM side handshake (out_ready_i)
//   rd_*_o, mem_*_o     registered payload; holds its last value during bubbles
//   stall_cnt_o         saturating count of cycles with out_valid_o=1, out_ready_i=0
//
// Skid FSM (EX_MEM_SKID_BUF_EN):
//   state   | meaning
//   S_EMPTY | no beat held
//   S_ONE   | main register holds the oldest beat
//   S_TWO   | main holds the oldest beat, skid holds the next one; input stalled
module ex_mem_pipe #(
  parameter int REG_W      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  rd_we_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [REG_W-1:0]      rd_data_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [REG_W-1:0]      mem_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  rd_we_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_W-1:0]      rd_data_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [1:0]            mem_size_o,
  output logic [REG_W-1:0]      mem_wdata_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int PL_W = 1 + REG_ADDR_W + REG_W + 1 + 1 + 2 + REG_W;

  logic [PL_W-1:0]  w_in_pl;
  logic [PL_W-1:0]  r_main;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_pl = {rd_we_i, rd_addr_i, rd_data_i, mem_re_i, mem_we_i,
                    mem_size_i, mem_wdata_i};

`ifdef EX_MEM_SKID_BUF_EN
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PL_W-1:0] r_skid;
  logic            r_in_ready;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_ready  = r_in_ready;
  assign w_accept    = in_valid_i & r_in_ready;
  assign w_drain     = w_out_valid & out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_drain)      w_state_nxt = S_TWO;
          else if (!w_accept && w_drain) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_drain) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is registered from the next state, so out_ready_i never
      // reaches in_ready_o combinationally.
      r_in_ready <= (w_state_nxt != S_TWO);
      if (!flush_i) begin
        case (r_state)
          S_EMPTY: if (w_accept) r_main <= w_in_pl;
          S_ONE: begin
            if (w_accept && w_drain) r_main <= w_in_pl;
            else if (w_accept)       r_skid <= w_in_pl;
          end
          S_TWO:   if (w_drain) r_main <= r_skid;
          default: ;
        endcase
      end
    end
  end
`else
  logic r_valid;

  assign w_out_valid = r_valid;
  assign w_in_ready  = !r_valid | out_ready_i;
  assign w_accept    = in_valid_i & w_in_ready;
  assign w_drain     = r_valid & out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_main  <= w_in_pl;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign stall_cnt_o = r_stall_cnt;
  assign {rd_we_o, rd_addr_o, rd_data_o, mem_re_o, mem_we_o,
          mem_size_o, mem_wdata_o} = r_main;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_wdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.REG_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_wdata_i(mem_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_wdata_o(mem_wdata_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned q[$];
    int sent, rcvd, occ, stall_exp;
    logic acc_in, acc_out;
    logic [31:0] pat;

    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    rd_we_i = 1'b0; rd_addr_i = '0; rd_data_i = '0; mem_re_i = 1'b0;
    mem_we_i = 1'b0; mem_size_i = '0; mem_wdata_i = '0;

    // Reset and first beat
    repeat (3) tick();
    check("rst_valid", out_valid_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_payload", {rd_we_o, rd_addr_o, rd_data_o, mem_re_o, mem_we_o, mem_size_o}, 0);
    check("rst_wdata", mem_wdata_o, 0);
    rst_n = 1'b1;
    in_valid_i = 1'b1; rd_we_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'h1234;
    out_ready_i = 1'b1;
    #1;
    check("rst_in_ready", in_ready_o, 1);
    tick();
    check("first_valid", out_valid_o, 1);
    check("first_we", rd_we_o, 1);
    check("first_addr", rd_addr_o, 5);
    check("first_data", rd_data_o, 32'h1234);
    in_valid_i = 1'b0;
    tick();
    check("bubble_valid", out_valid_o, 0);
    check("bubble_hold", rd_data_o, 32'h1234);

    // Store beat with rd_we=0
    in_valid_i = 1'b1; rd_we_i = 1'b0; rd_addr_i = 5'd0; mem_we_i = 1'b1;
    mem_size_i = 2'd2; rd_data_i = 32'h8000_0010; mem_wdata_i = 32'hDEAD_BEEF;
    tick();
    check("store_valid", out_valid_o, 1);
    check("store_we", {rd_we_o, mem_re_o, mem_we_o}, 3'b001);
    check("store_size", mem_size_o, 2);
    check("store_addr", rd_data_o, 32'h8000_0010);
    check("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);

    // Reserved size and illegal re+we pass through
    mem_re_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'd3; rd_data_i = 32'h44;
    tick();
    check("odd_flags", {mem_re_o, mem_we_o, mem_size_o}, 4'b1111);
    check("odd_data", rd_data_o, 32'h44);
    in_valid_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0;
    tick();

    // Backpressure burst: 8 beats against a fixed ready pattern
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pat = 32'b1011_0110_1001_1010_0101_1101_0010_1001;
    sent = 0; rcvd = 0; occ = 0; stall_exp = 0;
    for (int c = 0; c < 48 && rcvd < 8; c++) begin
      in_valid_i  = (sent < 8);
      rd_we_i     = 1'b1;
      rd_data_i   = 32'(sent + 1);
      rd_addr_i   = 5'(sent + 1);
      out_ready_i = pat[c % 32];
      #1;
      check("burst_valid", out_valid_o, (occ > 0));
`ifdef EX_MEM_SKID_BUF_EN
      check("burst_ready", in_ready_o, (occ < 2));
`else
      check("burst_ready", in_ready_o, (occ == 0) || out_ready_i);
`endif
      if (out_valid_o && q.size() > 0) begin
        check("burst_data", rd_data_o, q[0]);
        check("burst_addr", rd_addr_o, 5'(q[0]));
      end
      acc_out = out_valid_o & out_ready_i;
      acc_in  = in_valid_i & in_ready_o;
      if (occ > 0 && !out_ready_i && stall_exp < 15) stall_exp++;
      if (acc_out && q.size() > 0) begin
        void'(q.pop_front());
        rcvd++;
        occ--;
      end
      if (acc_in) begin
        q.push_back(sent + 1);
        sent++;
        occ++;
      end
      tick();
    end
    in_valid_i = 1'b0;
    check("burst_count", rcvd, 8);
    check("burst_stall", stall_cnt_o, stall_exp);

    // Flush with held beats and a simultaneous input beat
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; rd_data_i = 32'hA1;
    tick();
`ifdef EX_MEM_SKID_BUF_EN
    rd_data_i = 32'hB2;
    tick();
    check("pre_flush_ready", in_ready_o, 0);
`else
    check("pre_flush_ready", in_ready_o, 0);
`endif
    flush_i = 1'b1; in_valid_i = 1'b1; rd_data_i = 32'hF1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    check("flush_valid", out_valid_o, 0);
    check("flush_ready", in_ready_o, 1);
    check("flush_payload_kept", rd_data_o, 32'hA1);
`ifdef EX_MEM_SKID_BUF_EN
    check("flush_stall", stall_cnt_o, 2);
`else
    check("flush_stall", stall_cnt_o, 1);
`endif
    out_ready_i = 1'b1;
    tick();
    check("flush_no_ghost", out_valid_o, 0);

    // Counter saturation at 15
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; rd_we_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h55AA;
    mem_wdata_i = 32'h77;
    tick();
    in_valid_i = 1'b0;
    repeat (20) tick();
    check("sat_stall", stall_cnt_o, 15);
    check("sat_valid", out_valid_o, 1);
    check("sat_hold", rd_data_o, 32'h55AA);

    // Reset while a stalled beat is held
    rst_n = 1'b0;
    tick();
    check("midrst_valid", out_valid_o, 0);
    check("midrst_stall", stall_cnt_o, 0);
    check("midrst_payload", {rd_we_o, rd_addr_o, rd_data_o}, 0);
    check("midrst_wdata", mem_wdata_o, 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
